// File: rtl/irq_ctrl.sv
// ----------------------------------------------------------------------------
// Module   : irq_ctrl
// Brief    : Fixed-priority interrupt controller with bus-mapped PENDING,
//            ENABLE, STATUS and SWTRIG registers and an ASSERT/ACK/EOI sequence.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module irq_ctrl #(
  parameter int N_SRC = 4
) (
  input  logic             i_CLK,
  input  logic             i_RST,
  input  logic             i_CE,
  input  logic             i_REQ,
  input  logic             i_WE,
  input  logic [3:0]       i_ADDR,
  input  logic [31:0]      i_WDATA,
  output logic [31:0]      o_RDATA,
  output logic             o_GNT,
  input  logic [N_SRC-1:0] i_IRQ_SRC,
  output logic             o_IRQ,
  output logic [2:0]       o_IRQ_ID,
  input  logic             i_IRQ_ACK,
  input  logic             i_IRQ_EOI
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] enable_q, enable_d;
  logic [N_SRC-1:0] src_q, src_d;
  logic             irq_q, irq_d;
  logic [2:0]       irq_id_q, irq_id_d;

  logic             wr;
  logic [1:0]       sel;
  logic [N_SRC-1:0] w1c, swtrig, rise, active, id_hit, ack_clr;
  logic [2:0]       first_idx;
  logic             ack_take;
  logic [31:0]      rd_mux;
  logic             unused_bits;

  assign unused_bits = ^{i_ADDR[1:0], i_WDATA};

  always_comb begin
    wr     = i_CE & i_REQ & i_WE;
    sel    = i_ADDR[3:2];
    w1c    = (wr && sel == 2'd0) ? i_WDATA[N_SRC-1:0] : '0;
    swtrig = (wr && sel == 2'd3) ? i_WDATA[N_SRC-1:0] : '0;
    rise   = i_IRQ_SRC & ~src_q;
    src_d  = i_IRQ_SRC;
    active = pending_q & enable_q;

    id_hit    = '0;
    first_idx = 3'd0;
    for (int i = 0; i < N_SRC; i++) begin
      id_hit[i] = (irq_id_q == 3'(i));
    end
    // Walk downward so the lowest index (highest priority) wins.
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (active[i]) first_idx = 3'(i);
    end

    ack_take  = (state_q == ASSERT) && i_IRQ_ACK;
    ack_clr   = ack_take ? id_hit : '0;
    pending_d = (pending_q & ~w1c & ~ack_clr) | rise | swtrig;
    enable_d  = (wr && sel == 2'd1) ? i_WDATA[N_SRC-1:0] : enable_q;
  end

  always_comb begin
    state_d  = state_q;
    irq_d    = irq_q;
    irq_id_d = irq_id_q;
    case (state_q)
      IDLE: begin
        if (|active) begin
          irq_id_d = first_idx;
          irq_d    = 1'b1;
          state_d  = ASSERT;
        end
      end
      ASSERT: begin
        // The asserted ID stays frozen; a withdrawn request drops back to IDLE.
        if (ack_take) begin
          irq_d   = 1'b0;
          state_d = SERVICE;
        end else if (!(|(active & id_hit))) begin
          irq_d   = 1'b0;
          state_d = IDLE;
        end
      end
      SERVICE: begin
        irq_d = 1'b0;
        if (i_IRQ_EOI) state_d = IDLE;
      end
      default: begin
        irq_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q   <= IDLE;
      pending_q <= '0;
      enable_q  <= '0;
      src_q     <= '0;
      irq_q     <= 1'b0;
      irq_id_q  <= 3'd0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      enable_q  <= enable_d;
      src_q     <= src_d;
      irq_q     <= irq_d;
      irq_id_q  <= irq_id_d;
    end
  end

  always_comb begin
    rd_mux = 32'd0;
    case (i_ADDR[3:2])
      2'd0:    rd_mux = 32'(pending_q);
      2'd1:    rd_mux = 32'(enable_q);
      2'd2:    rd_mux = {21'd0, irq_id_q, 6'd0, state_q};
      default: rd_mux = 32'd0;
    endcase
  end

  assign o_GNT    = i_REQ & i_CE;
  assign o_RDATA  = o_GNT ? rd_mux : 32'd0;
  assign o_IRQ    = irq_q;
  assign o_IRQ_ID = irq_id_q;

endmodule

`default_nettype wire

// File: tb/tb_irq_ctrl.sv
// ----------------------------------------------------------------------------
// Module   : tb_irq_ctrl
// Brief    : Cycle-vector bench for irq_ctrl with an output scoreboard queue.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst, ce, req, we, ack, eoi;
  logic [3:0]  addr, src;
  logic [31:0] wdata, rdata;
  logic        gnt, irq;
  logic [2:0]  irq_id;

  always #5 clk = ~clk;

  irq_ctrl #(.N_SRC(4)) dut (
    .i_CLK(clk), .i_RST(rst), .i_CE(ce), .i_REQ(req), .i_WE(we),
    .i_ADDR(addr), .i_WDATA(wdata), .o_RDATA(rdata), .o_GNT(gnt),
    .i_IRQ_SRC(src), .o_IRQ(irq), .o_IRQ_ID(irq_id),
    .i_IRQ_ACK(ack), .i_IRQ_EOI(eoi)
  );

  typedef struct {
    logic        rst, bus, we;
    logic [1:0]  idx;
    logic [31:0] wdata;
    logic [3:0]  src;
    logic        ack, eoi, chk_rd;
    logic [31:0] exp_rd;
    logic        exp_irq;
    logic [2:0]  exp_id;
  } vec_t;

  typedef struct {
    logic       irq;
    logic [2:0] id;
    int         tag;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  function automatic vec_t v_nop(logic [3:0] s, logic a, logic e, logic xi, logic [2:0] xd);
    vec_t v = '{rst:0, bus:0, we:0, idx:0, wdata:0, src:s, ack:a, eoi:e,
                chk_rd:0, exp_rd:0, exp_irq:xi, exp_id:xd};
    return v;
  endfunction

  function automatic vec_t v_wr(logic [1:0] r, logic [31:0] d, logic [3:0] s,
                                logic xi, logic [2:0] xd);
    vec_t v = v_nop(s, 1'b0, 1'b0, xi, xd);
    v.bus = 1; v.we = 1; v.idx = r; v.wdata = d;
    return v;
  endfunction

  function automatic vec_t v_rd(logic [1:0] r, logic [31:0] x, logic [3:0] s,
                                logic xi, logic [2:0] xd);
    vec_t v = v_nop(s, 1'b0, 1'b0, xi, xd);
    v.bus = 1; v.idx = r; v.chk_rd = 1; v.exp_rd = x;
    return v;
  endfunction

  function automatic vec_t v_rst();
    vec_t v = v_nop(4'h0, 1'b0, 1'b0, 1'b0, 3'd0);
    v.rst = 1;
    return v;
  endfunction

  task automatic step(input vec_t v, input int tag);
    exp_t e;
    @(negedge clk);
    rst = v.rst; ce = v.bus; req = v.bus; we = v.we;
    addr = {v.idx, 2'b00}; wdata = v.wdata; src = v.src;
    ack = v.ack; eoi = v.eoi;
    e.irq = v.exp_irq; e.id = v.exp_id; e.tag = tag;
    sb.push_back(e);
    #1;
    if (v.chk_rd) begin
      checks++;
      if (rdata !== v.exp_rd || gnt !== 1'b1) begin
        failures++;
        $display("FAIL rdata vec=%0d got=0x%08h gnt=%b want=0x%08h", tag, rdata, gnt, v.exp_rd);
      end
    end
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    if (irq !== e.irq || irq_id !== e.id) begin
      failures++;
      $display("FAIL irq vec=%0d got irq=%b id=%0d want irq=%b id=%0d",
               e.tag, irq, irq_id, e.irq, e.id);
    end
  endtask

  initial begin
    rst = 1; ce = 0; req = 0; we = 0; addr = 0; wdata = 0; src = 0; ack = 0; eoi = 0;

    // Reset, then idle reads
    vecs.push_back(v_rst());
    vecs.push_back(v_rd(2'd0, 32'h0, 4'h0, 0, 3'd0));
    vecs.push_back(v_rd(2'd2, 32'h0, 4'h0, 0, 3'd0));
    // Single pulse on SRC[0] with ENABLE=1
    vecs.push_back(v_wr(2'd1, 32'h1, 4'h0, 0, 3'd0));
    vecs.push_back(v_nop(4'h1, 0, 0, 0, 3'd0));
    vecs.push_back(v_nop(4'h0, 0, 0, 1, 3'd0));
    vecs.push_back(v_rd(2'd2, 32'h1, 4'h0, 1, 3'd0));
    vecs.push_back(v_nop(4'h0, 1, 0, 0, 3'd0));
    vecs.push_back(v_rd(2'd0, 32'h0, 4'h0, 0, 3'd0));
    vecs.push_back(v_rd(2'd2, 32'h2, 4'h0, 0, 3'd0));
    vecs.push_back(v_nop(4'h0, 0, 1, 0, 3'd0));
    // Simultaneous SRC[2] and SRC[1]: priority then re-assert after EOI
    vecs.push_back(v_wr(2'd1, 32'hF, 4'h0, 0, 3'd0));
    vecs.push_back(v_nop(4'h6, 0, 0, 0, 3'd0));
    vecs.push_back(v_nop(4'h0, 0, 0, 1, 3'd1));
    vecs.push_back(v_nop(4'h0, 1, 0, 0, 3'd1));
    vecs.push_back(v_nop(4'h0, 0, 1, 0, 3'd1));
    vecs.push_back(v_nop(4'h0, 0, 0, 1, 3'd2));
    vecs.push_back(v_rd(2'd2, 32'h201, 4'h0, 1, 3'd2));
    vecs.push_back(v_nop(4'h0, 1, 0, 0, 3'd2));
    vecs.push_back(v_nop(4'h0, 0, 1, 0, 3'd2));
    // Pending while disabled, then enable
    vecs.push_back(v_wr(2'd1, 32'h0, 4'h0, 0, 3'd2));
    vecs.push_back(v_nop(4'h8, 0, 0, 0, 3'd2));
    vecs.push_back(v_rd(2'd0, 32'h8, 4'h0, 0, 3'd2));
    vecs.push_back(v_wr(2'd1, 32'h8, 4'h0, 0, 3'd2));
    vecs.push_back(v_nop(4'h0, 0, 0, 1, 3'd3));
    vecs.push_back(v_nop(4'h0, 1, 0, 0, 3'd3));
    vecs.push_back(v_nop(4'h0, 0, 1, 0, 3'd3));
    // W1C withdraws an asserted request; W1C racing a rise keeps the bit
    vecs.push_back(v_wr(2'd1, 32'hF, 4'h0, 0, 3'd3));
    vecs.push_back(v_nop(4'h1, 0, 0, 0, 3'd3));
    vecs.push_back(v_nop(4'h0, 0, 0, 1, 3'd0));
    vecs.push_back(v_wr(2'd0, 32'h1, 4'h0, 1, 3'd0));
    vecs.push_back(v_nop(4'h0, 0, 0, 0, 3'd0));
    vecs.push_back(v_rd(2'd0, 32'h0, 4'h0, 0, 3'd0));
    vecs.push_back(v_wr(2'd0, 32'h1, 4'h1, 0, 3'd0));
    vecs.push_back(v_rd(2'd0, 32'h1, 4'h0, 1, 3'd0));
    vecs.push_back(v_nop(4'h0, 1, 0, 0, 3'd0));
    // SWTRIG during SERVICE waits for EOI; stray EOI/ACK ignored
    vecs.push_back(v_wr(2'd3, 32'h4, 4'h0, 0, 3'd0));
    vecs.push_back(v_rd(2'd0, 32'h4, 4'h0, 0, 3'd0));
    vecs.push_back(v_rd(2'd3, 32'h0, 4'h0, 0, 3'd0));
    vecs.push_back(v_nop(4'h0, 0, 1, 0, 3'd0));
    vecs.push_back(v_nop(4'h0, 0, 0, 1, 3'd2));
    vecs.push_back(v_nop(4'h0, 0, 1, 1, 3'd2));
    vecs.push_back(v_nop(4'h0, 1, 0, 0, 3'd2));
    vecs.push_back(v_rd(2'd2, 32'h202, 4'h0, 0, 3'd2));
    // Reset during SERVICE with everything pending
    vecs.push_back(v_wr(2'd3, 32'hF, 4'h0, 0, 3'd2));
    vecs.push_back(v_rd(2'd0, 32'hF, 4'h0, 0, 3'd2));
    vecs.push_back(v_rst());
    vecs.push_back(v_rd(2'd0, 32'h0, 4'h0, 0, 3'd0));
    vecs.push_back(v_rd(2'd1, 32'h0, 4'h0, 0, 3'd0));
    vecs.push_back(v_rd(2'd2, 32'h0, 4'h0, 0, 3'd0));
    vecs.push_back(v_nop(4'h0, 0, 0, 0, 3'd0));

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);

    // Held-high source captures once and re-arms only after a low cycle
    step(v_nop(4'h1, 0, 0, 0, 3'd0), 100);
    step(v_wr(2'd0, 32'h1, 4'h1, 0, 3'd0), 101);
    step(v_rd(2'd0, 32'h0, 4'h1, 0, 3'd0), 102);
    step(v_nop(4'h0, 0, 0, 0, 3'd0), 103);
    step(v_nop(4'h1, 0, 0, 0, 3'd0), 104);
    step(v_rd(2'd0, 32'h1, 4'h1, 0, 3'd0), 105);
    // Bits above N_SRC are dropped on write and read back as zero
    step(v_wr(2'd1, 32'hFFFF_FFFF, 4'h0, 0, 3'd0), 106);
    step(v_rd(2'd1, 32'hF, 4'h0, 1, 3'd0), 107);

    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard residue got=%0d want=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
